// File: rtl/sync_fifo_pkg.sv
// ============================================================================
// Module : sync_fifo_pkg
// Brief  : Shared types, pointer sizing and parameter legality for the FIFO.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sync_fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // One extra MSB beyond the index distinguishes full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit params_legal(input int data_width, input int depth,
                                        input int af_thresh, input int ae_thresh,
                                        input int fwft);
        return (data_width >= 1) && is_pow2(depth)
            && (af_thresh >= 1) && (af_thresh <= depth)
            && (ae_thresh >= 0) && (ae_thresh <= depth - 1)
            && ((fwft == 0) || (fwft == 1));
    endfunction

endpackage : sync_fifo_pkg

`default_nettype wire

// File: rtl/sync_fifo_param_if.sv
// ============================================================================
// Module : sync_fifo_param_if
// Brief  : Producer/consumer bus of sync_fifo_param (data, handshake, flags).
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface sync_fifo_param_if
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
);
    localparam int c_PW = ptr_width(DEPTH);

    logic                  w_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [c_PW-1:0]       count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output w_en, data_in, r_en,
        input  data_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  w_en, data_in, r_en,
        output data_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface : sync_fifo_param_if

`default_nettype wire

// File: rtl/fifo_mem_2p.sv
// ============================================================================
// Module : fifo_mem_2p
// Brief  : Dual-port storage, one synchronous write port, one async read port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fifo_mem_2p #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  wire logic                     clk,
    input  wire logic                     i_we,
    input  wire logic [$clog2(DEPTH)-1:0] i_waddr,
    input  wire logic [DATA_WIDTH-1:0]    i_wdata,
    input  wire logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic      [DATA_WIDTH-1:0]    o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : fifo_mem_2p

`default_nettype wire

// File: rtl/sync_fifo_param.sv
// ============================================================================
// Module : sync_fifo_param
// Brief  : Single-clock FIFO with count, almost flags, error pulses and FWFT.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = DEPTH - 1,
    parameter int AE_THRESH  = 1,
    parameter int FWFT       = 0
) (
    input  wire logic         clk,
    input  wire logic         rst,
    sync_fifo_param_if.slave  bus
);

    localparam int              c_AW   = $clog2(DEPTH);
    localparam int              c_PW   = ptr_width(DEPTH);
    localparam fifo_mode_e      c_MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
    localparam logic [c_PW-1:0] c_AF   = c_PW'(AF_THRESH);
    localparam logic [c_PW-1:0] c_AE   = c_PW'(AE_THRESH);

    if (!params_legal(DATA_WIDTH, DEPTH, AF_THRESH, AE_THRESH, FWFT)) begin : g_param_check
        $error("sync_fifo_param: illegal parameter combination");
    end

    logic [c_PW-1:0]       r_wptr;
    logic [c_PW-1:0]       r_rptr;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_full;
    logic                  w_empty;
    logic [c_PW-1:0]       w_count;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [DATA_WIDTH-1:0] w_rdata;

    // Flags depend only on the registered pointers, never on w_en/r_en.
    assign w_full   = (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]) && (r_wptr[c_AW] != r_rptr[c_AW]);
    assign w_empty  = (r_wptr == r_rptr);
    assign w_count  = r_wptr - r_rptr;
    assign w_wr_acc = bus.w_en && !w_full && !rst;
    assign w_rd_acc = bus.r_en && !w_empty && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_overflow  <= bus.w_en && w_full;
            r_underflow <= bus.r_en && w_empty;
        end
    end

    fifo_mem_2p #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wptr[c_AW-1:0]),
        .i_wdata (bus.data_in),
        .i_raddr (r_rptr[c_AW-1:0]),
        .o_rdata (w_rdata)
    );

    if (c_MODE == FIFO_FWFT) begin : g_fwft
        assign bus.data_out = w_empty ? '0 : w_rdata;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] r_dout;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_dout <= '0;
            end else if (w_rd_acc) begin
                r_dout <= w_rdata;
            end
        end

        assign bus.data_out = r_dout;
    end

    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.count        = w_count;
    assign bus.almost_full  = (w_count >= c_AF);
    assign bus.almost_empty = (w_count <= c_AE);
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule : sync_fifo_param

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
// ============================================================================
// Module : tb_sync_fifo_param
// Brief  : Directed self-checking bench for standard and FWFT FIFO instances.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sync_fifo_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_WIDTH(8), .DEPTH(8)) bus_s ();
    sync_fifo_param_if #(.DATA_WIDTH(8), .DEPTH(8)) bus_f ();

    sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(8), .AF_THRESH(7), .AE_THRESH(1), .FWFT(0))
        u_dut_std (.clk(clk), .rst(rst), .bus(bus_s));

    sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(8), .AF_THRESH(7), .AE_THRESH(1), .FWFT(1))
        u_dut_fwft (.clk(clk), .rst(rst), .bus(bus_f));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_s(input logic we, input logic [7:0] d, input logic re);
        bus_s.w_en = we; bus_s.data_in = d; bus_s.r_en = re;
    endtask

    task automatic drive_f(input logic we, input logic [7:0] d, input logic re);
        bus_f.w_en = we; bus_f.data_in = d; bus_f.r_en = re;
    endtask

    task automatic test_reset();
        drive_s(1'b0, 8'h00, 1'b0);
        drive_f(1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        n_checks++;
        if (bus_s.count !== 4'd0 || bus_s.empty !== 1'b1 || bus_s.full !== 1'b0 ||
            bus_s.almost_empty !== 1'b1 || bus_s.almost_full !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flags got cnt=%0d e=%b f=%b ae=%b af=%b exp cnt=0 e=1 f=0 ae=1 af=0",
                     bus_s.count, bus_s.empty, bus_s.full, bus_s.almost_empty, bus_s.almost_full);
        end
        n_checks++;
        if (bus_s.overflow !== 1'b0 || bus_s.underflow !== 1'b0 || bus_s.data_out !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_out got ovf=%b udf=%b dout=%h exp 0 0 00",
                     bus_s.overflow, bus_s.underflow, bus_s.data_out);
        end
        n_checks++;
        if (bus_f.empty !== 1'b1 || bus_f.data_out !== 8'h00 || bus_f.count !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_fwft got e=%b dout=%h cnt=%0d exp 1 00 0",
                     bus_f.empty, bus_f.data_out, bus_f.count);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            drive_s(1'b1, 8'(i), 1'b0);
            step();
            n_checks++;
            if (bus_s.count !== 4'(i) || bus_s.full !== (i == 8) ||
                bus_s.almost_full !== (i >= 7) || bus_s.almost_empty !== (i <= 1) ||
                bus_s.empty !== 1'b0) begin
                n_errors++;
                $display("FAIL fill i=%0d got cnt=%0d f=%b af=%b ae=%b e=%b", i,
                         bus_s.count, bus_s.full, bus_s.almost_full, bus_s.almost_empty, bus_s.empty);
            end
        end
        drive_s(1'b1, 8'hFF, 1'b0);
        step();
        n_checks++;
        if (bus_s.overflow !== 1'b1 || bus_s.count !== 4'd8) begin
            n_errors++;
            $display("FAIL overflow got ovf=%b cnt=%0d exp 1 8", bus_s.overflow, bus_s.count);
        end
        drive_s(1'b0, 8'h00, 1'b0);
        step();
        n_checks++;
        if (bus_s.overflow !== 1'b0 || bus_s.count !== 4'd8) begin
            n_errors++;
            $display("FAIL overflow_clear got ovf=%b cnt=%0d exp 0 8", bus_s.overflow, bus_s.count);
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 8; i++) begin
            drive_s(1'b0, 8'h00, 1'b1);
            step();
            n_checks++;
            if (bus_s.data_out !== 8'(i) || bus_s.count !== 4'(8 - i) ||
                bus_s.almost_empty !== ((8 - i) <= 1) || bus_s.empty !== (i == 8) ||
                bus_s.almost_full !== ((8 - i) >= 7)) begin
                n_errors++;
                $display("FAIL drain i=%0d got dout=%h cnt=%0d ae=%b e=%b af=%b exp dout=%h", i,
                         bus_s.data_out, bus_s.count, bus_s.almost_empty, bus_s.empty,
                         bus_s.almost_full, 8'(i));
            end
        end
        drive_s(1'b0, 8'h00, 1'b1);
        step();
        n_checks++;
        if (bus_s.underflow !== 1'b1 || bus_s.data_out !== 8'h08 || bus_s.count !== 4'd0) begin
            n_errors++;
            $display("FAIL underflow got udf=%b dout=%h cnt=%0d exp 1 08 0",
                     bus_s.underflow, bus_s.data_out, bus_s.count);
        end
        drive_s(1'b0, 8'h00, 1'b0);
        step();
        n_checks++;
        if (bus_s.underflow !== 1'b0) begin
            n_errors++;
            $display("FAIL underflow_clear got udf=%b exp 0", bus_s.underflow);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            drive_s(1'b1, 8'(8'h10 + i), 1'b0);
            step();
        end
        for (int k = 0; k < 20; k++) begin
            drive_s(1'b1, 8'(8'h14 + k), 1'b1);
            step();
            n_checks++;
            if (bus_s.data_out !== 8'(8'h10 + k) || bus_s.count !== 4'd4) begin
                n_errors++;
                $display("FAIL b2b k=%0d got dout=%h cnt=%0d exp dout=%h cnt=4",
                         k, bus_s.data_out, bus_s.count, 8'(8'h10 + k));
            end
        end
        for (int k = 0; k < 4; k++) begin
            drive_s(1'b0, 8'h00, 1'b1);
            step();
            n_checks++;
            if (bus_s.data_out !== 8'(8'h24 + k) || bus_s.count !== 4'(3 - k)) begin
                n_errors++;
                $display("FAIL b2b_drain k=%0d got dout=%h cnt=%0d exp dout=%h cnt=%0d",
                         k, bus_s.data_out, bus_s.count, 8'(8'h24 + k), 3 - k);
            end
        end
        drive_s(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_corner_full();
        for (int i = 0; i < 8; i++) begin
            drive_s(1'b1, 8'(8'h30 + i), 1'b0);
            step();
        end
        drive_s(1'b1, 8'hEE, 1'b1);
        step();
        n_checks++;
        if (bus_s.overflow !== 1'b1 || bus_s.count !== 4'd7 || bus_s.data_out !== 8'h30 ||
            bus_s.full !== 1'b0) begin
            n_errors++;
            $display("FAIL corner_full got ovf=%b cnt=%0d dout=%h f=%b exp 1 7 30 0",
                     bus_s.overflow, bus_s.count, bus_s.data_out, bus_s.full);
        end
        for (int i = 1; i < 8; i++) begin
            drive_s(1'b0, 8'h00, 1'b1);
            step();
            n_checks++;
            if (bus_s.data_out !== 8'(8'h30 + i)) begin
                n_errors++;
                $display("FAIL corner_full_drain i=%0d got dout=%h exp %h",
                         i, bus_s.data_out, 8'(8'h30 + i));
            end
        end
        drive_s(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_corner_empty();
        drive_s(1'b1, 8'h55, 1'b1);
        step();
        n_checks++;
        if (bus_s.underflow !== 1'b1 || bus_s.count !== 4'd1 || bus_s.data_out !== 8'h37) begin
            n_errors++;
            $display("FAIL corner_empty got udf=%b cnt=%0d dout=%h exp 1 1 37",
                     bus_s.underflow, bus_s.count, bus_s.data_out);
        end
        drive_s(1'b0, 8'h00, 1'b1);
        step();
        n_checks++;
        if (bus_s.data_out !== 8'h55 || bus_s.count !== 4'd0 || bus_s.underflow !== 1'b0) begin
            n_errors++;
            $display("FAIL corner_empty_read got dout=%h cnt=%0d udf=%b exp 55 0 0",
                     bus_s.data_out, bus_s.count, bus_s.underflow);
        end
        drive_s(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_fwft();
        drive_f(1'b1, 8'hA5, 1'b0);
        step();
        drive_f(1'b0, 8'h00, 1'b0);
        n_checks++;
        if (bus_f.data_out !== 8'hA5 || bus_f.empty !== 1'b0) begin
            n_errors++;
            $display("FAIL fwft_show got dout=%h e=%b exp a5 0", bus_f.data_out, bus_f.empty);
        end
        drive_f(1'b0, 8'h00, 1'b1);
        step();
        drive_f(1'b0, 8'h00, 1'b0);
        n_checks++;
        if (bus_f.data_out !== 8'h00 || bus_f.empty !== 1'b1) begin
            n_errors++;
            $display("FAIL fwft_pop got dout=%h e=%b exp 00 1", bus_f.data_out, bus_f.empty);
        end
        drive_f(1'b1, 8'h11, 1'b0); step();
        drive_f(1'b1, 8'h22, 1'b0); step();
        drive_f(1'b0, 8'h00, 1'b1); step();
        drive_f(1'b0, 8'h00, 1'b0);
        n_checks++;
        if (bus_f.data_out !== 8'h22 || bus_f.count !== 4'd1) begin
            n_errors++;
            $display("FAIL fwft_second got dout=%h cnt=%0d exp 22 1", bus_f.data_out, bus_f.count);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            drive_s(1'b1, 8'(8'h40 + i), 1'b0);
            step();
        end
        drive_s(1'b1, 8'h99, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive_s(1'b0, 8'h00, 1'b0);
        n_checks++;
        if (bus_s.count !== 4'd0 || bus_s.empty !== 1'b1 || bus_s.full !== 1'b0 ||
            bus_s.data_out !== 8'h00 || bus_s.overflow !== 1'b0 || bus_s.underflow !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid got cnt=%0d e=%b f=%b dout=%h ovf=%b udf=%b exp 0 1 0 00 0 0",
                     bus_s.count, bus_s.empty, bus_s.full, bus_s.data_out,
                     bus_s.overflow, bus_s.underflow);
        end
        drive_s(1'b1, 8'h77, 1'b0); step();
        drive_s(1'b0, 8'h00, 1'b1); step();
        drive_s(1'b0, 8'h00, 1'b0);
        n_checks++;
        if (bus_s.data_out !== 8'h77 || bus_s.empty !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid_new got dout=%h e=%b exp 77 1", bus_s.data_out, bus_s.empty);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_corner_full();
        test_corner_empty();
        test_fwft();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_sync_fifo_param

`default_nettype wire

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO, the next generation of the team's synchronous FIFO. It adds occupancy count, programmable almost-full/almost-empty thresholds, overflow/underflow error pulses, full use of all DEPTH entries, and a selectable first-word-fall-through (FWFT) read mode. It buffers data between producer and consumer logic in the same clock domain.

## Interface
- DATA_WIDTH, 8: word width in bits, ≥1
- DEPTH, 8: number of entries; power of two, ≥2
- AF_THRESH, DEPTH-1: almost_full asserts when count ≥ AF_THRESH; range 1..DEPTH
- AE_THRESH, 1: almost_empty asserts when count ≤ AE_THRESH; range 0..DEPTH-1
- FWFT, 0: 0 = standard registered read, 1 = first-word-fall-through
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous reset, active-high
- w_en  in  1  write request
- data_in  in  DATA_WIDTH  write data
- r_en  in  1  read request (pop in FWFT mode)
- data_out  out  DATA_WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_THRESH
- almost_empty  out  1  count ≤ AE_THRESH
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: write attempted while full
- underflow  out  1  one-cycle pulse: read attempted while empty

## Operation
- Pointers: w_ptr and r_ptr, each $clog2(DEPTH)+1 bits. The extra MSB is the wrap bit. The index is ptr[$clog2(DEPTH)-1:0] and increments wrap naturally mod 2·DEPTH.
- full = (index equal && wrap bits differ); empty = (w_ptr == r_ptr). All DEPTH entries are usable.
- A write is accepted iff w_en && !full, using pre-edge flags. The word is stored at w_ptr and w_ptr increments.
- A read is accepted iff r_en && !empty, using pre-edge flags. r_ptr increments.
- Simultaneous write and read on a non-full, non-empty FIFO: both are accepted and count is unchanged.
  - When full, only the read is accepted and the write raises overflow.
  - When empty, only the write is accepted and the read raises underflow.
- count = w_ptr − r_ptr (modulo pointer width). All flags are decoded from registered pointers, with no combinational path from w_en/r_en.
- overflow/underflow: registered, high for exactly the cycle after the offending request. They are not sticky.
- Standard mode (FWFT=0): on an accepted read, data_out loads mem[r_ptr] at that edge. Otherwise data_out holds its value.
- FWFT mode (FWFT=1): data_out = mem[r_ptr index] whenever !empty, and 0 when empty. r_en acknowledges and pops the shown word.
- Storage array is not reset.
- Reset (rst high at an edge) forces:
  - pointers 0, count 0
  - empty 1, full 0
  - almost_empty 1, almost_full 0
  - overflow 0, underflow 0
  - data_out 0
- w_en/r_en are ignored during reset. Reset mid-operation discards all contents.

## Timing
- Write at edge N: count, empty, full and almost_* reflect it after edge N.
- Standard read latency: 1 cycle. r_en sampled at edge N gives data on data_out after edge N.
- FWFT: a word written into an empty FIFO at edge N appears on data_out after edge N. This is 0 cycles of read latency relative to empty deasserting.
- Sustained 1 write + 1 read per cycle with no bubbles, at any occupancy 1..DEPTH−1.
- Error pulses appear the cycle after the request edge.

## Structure
- Package sync_fifo_pkg holds:
  - a ptr-width function, clog2(DEPTH)+1
  - a mode enum: FIFO_STD, FIFO_FWFT
  - parameter-legality checks: DEPTH power of two, threshold ranges
- Sub-module fifo_mem_2p is a simple dual-port storage array with one write port and one asynchronous read port, parametrised in DATA_WIDTH/DEPTH. The top level holds pointers, flags, error pulses and the data_out register.

## Test plan
Default parameters (DATA_WIDTH=8, DEPTH=8, AF=7, AE=1) unless noted.
- Reset, then write 0x01..0x08 with no reads. After the 8th write: full=1, count=8, almost_full asserted at count 7. A 9th write (0xFF) gives an overflow pulse for 1 cycle, count stays 8, and 0xFF is never read.
- From full, read 8 times (FWFT=0). data_out = 0x01..0x08, each 1 cycle after its r_en. Then empty=1 and almost_empty asserted at count 1. A further r_en gives an underflow pulse for 1 cycle and data_out holds 0x08.
- Simultaneous w_en and r_en for 20 cycles at count 4, data 0x10 upward. count stays 4, and output order matches input order across pointer wrap (16+ pointer increments).
- Corner cases with simultaneous w_en/r_en:
  - When full: read accepted, write rejected, overflow=1, count 8→7.
  - When empty: write accepted, read rejected, underflow=1, count 0→1.
- FWFT=1: write 0xA5 into an empty FIFO. data_out=0xA5 the following cycle with no r_en. Pop with r_en: empty=1 and data_out=0.
- Fill to 5 entries, assert rst for 1 cycle while also asserting w_en. Afterwards: count=0, empty=1, full=0, data_out=0, error pulses 0. The next write/read returns the new word only.
